// File: rtl/pakout_arb.sv
// pakout_arb: round-robin arbiter of NCH debounced 4-phase message channels into
// a FIFO of whole messages, serialised as ceil(MSZ/PSZ) packets over a debounced
// 4-phase packet link.
// Optional feature: define NS_PAKOUT_HDR_EN to prefix every message with a header
// packet {zeros, src_idx, packet_count}.

// Debouncer: the filtered level follows raw only after CKS consecutive samples at
// the new level.
module pakout_arb_deb #(
  parameter int CKS = 2
) (
  input  logic i_clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(CKS + 1);

  logic [CW-1:0] cnt;

  // Count consecutive samples that disagree with the filtered level.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(CKS - 1)) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module pakout_arb #(
  parameter int NCH         = 2,
  parameter int MSZ         = 32,
  parameter int PSZ         = 8,
  parameter int FSZ         = 4,
  parameter int RCV_REQ_CKS = 2,
  parameter int SND_ACK_CKS = 2
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic               ready,
  input  logic [NCH-1:0]     rcv_req,
  input  logic [NCH*MSZ-1:0] rcv_data,
  output logic [NCH-1:0]     rcv_ack,
  output logic               snd_req,
  input  logic               snd_ack,
  output logic [PSZ-1:0]     snd_pakio,
  output logic               snd_last,
  output logic               busy
);
  localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ;
  localparam int CIW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PCW     = $clog2(TOT_PKS + 1);
  localparam int AW      = $clog2(FSZ);
`ifdef NS_PAKOUT_HDR_EN
  localparam int HDR     = 1;
  localparam int EW      = CIW + MSZ;
`else
  localparam int HDR     = 0;
  localparam int EW      = MSZ;
`endif
  localparam int NPK     = TOT_PKS + HDR;
  localparam int PADW    = TOT_PKS * PSZ;
  localparam logic [PCW-1:0] LAST_W   = PCW'(NPK - 1);
  localparam logic [AW:0]    FULL_CNT = FSZ[AW:0];

`ifdef NS_PAKOUT_HDR_EN
  localparam logic [PCW-1:0] TOT_W = PCW'(TOT_PKS);
  if (CIW + PCW > PSZ) begin : g_hdr_too_wide
    $error("pakout_arb: header {src_idx, count} does not fit in one packet");
  end
`endif

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  logic [NCH-1:0]     req_f;
  logic               ack_f;
  logic [EW-1:0]      mem [FSZ];
  logic [AW:0]        head, tail;
  logic               full, empty;
  logic [NCH-1:0]     elig;
  logic               push, pop;
  logic [CIW-1:0]     winner, cand, rr_ptr;
  logic [EW-1:0]      entry_in, entry_out;
  state_t             state_q, state_d;
  logic [PCW-1:0]     pk_idx;
  logic [NPK*PSZ-1:0] pk_reg;

  for (genvar i = 0; i < NCH; i++) begin : g_req_deb
    pakout_arb_deb #(.CKS(RCV_REQ_CKS)) u_deb (
      .i_clk(i_clk), .reset(reset), .raw(rcv_req[i]), .filt(req_f[i]));
  end

  pakout_arb_deb #(.CKS(SND_ACK_CKS)) u_ack_deb (
    .i_clk(i_clk), .reset(reset), .raw(snd_ack), .filt(ack_f));

  assign full  = (head - tail) == FULL_CNT;
  assign empty = (head == tail);
  assign elig  = req_f & ~rcv_ack & {NCH{!full}};

  // Pick the first eligible channel scanning upward from rr_ptr.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    push   = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CIW'((int'(rr_ptr) + k) % NCH);
      if (!push && elig[cand]) begin
        push   = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef NS_PAKOUT_HDR_EN
  assign entry_in = {winner, rcv_data[winner*MSZ +: MSZ]};
`else
  assign entry_in = rcv_data[winner*MSZ +: MSZ];
`endif
  assign entry_out = mem[tail[AW-1:0]];

  // Ready flag, acknowledges, round-robin pointer and FIFO pointers.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      ready   <= 1'b0;
      rcv_ack <= '0;
      rr_ptr  <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      ready <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (!req_f[i]) rcv_ack[i] <= 1'b0;
      end
      if (push) begin
        rcv_ack[winner] <= 1'b1;
        rr_ptr          <= CIW'((int'(winner) + 1) % NCH);
        head            <= head + 1'b1;
      end
      if (pop) tail <= tail + 1'b1;
    end
  end

  // FIFO storage write.
  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[head[AW-1:0]] <= entry_in;
  end

  // Output FSM state register.
  always_ff @(posedge i_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output FSM next state and FIFO pop.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:    if (!empty) begin
                 pop     = 1'b1;
                 state_d = SEND;
               end
      SEND:    if (ack_f) state_d = RELEASE;
      RELEASE: if (!ack_f) state_d = (pk_idx == LAST_W) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Packet index: cleared on load, advanced after each completed non-final packet.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      pk_idx <= '0;
    end else if (pop) begin
      pk_idx <= '0;
    end else if (state_q == RELEASE && !ack_f && pk_idx != LAST_W) begin
      pk_idx <= pk_idx + 1'b1;
    end
  end

  // Packet register: the whole message laid out packet by packet, header lowest.
  always_ff @(posedge i_clk) begin
    if (pop) begin
`ifdef NS_PAKOUT_HDR_EN
      pk_reg <= {PADW'(entry_out[MSZ-1:0]), PSZ'({entry_out[MSZ +: CIW], TOT_W})};
`else
      pk_reg <= PADW'(entry_out);
`endif
    end
  end

  assign snd_req   = (state_q == SEND);
  assign snd_last  = (state_q == SEND) && (pk_idx == LAST_W);
  assign snd_pakio = (state_q == SEND) ? pk_reg[pk_idx*PSZ +: PSZ] : '0;
  assign busy      = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_pakout_arb.sv
// Self-checking bench for pakout_arb: a queue-based transaction model predicts
// every output each cycle under directed and randomized 4-phase traffic.
module tb_pakout_arb;
  localparam int NCH = 2, MSZ = 32, PSZ = 8, FSZ = 4, RCK = 2, ACK = 2;
  localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ;
  localparam int PCW = $clog2(TOT_PKS + 1);
`ifdef NS_PAKOUT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic               i_clk = 1'b0;
  logic               reset = 1'b1;
  logic               ready;
  logic [NCH-1:0]     rcv_req = '0;
  logic [NCH*MSZ-1:0] rcv_data = '0;
  logic [NCH-1:0]     rcv_ack;
  logic               snd_req;
  logic               snd_ack = 1'b0;
  logic [PSZ-1:0]     snd_pakio;
  logic               snd_last;
  logic               busy;

  pakout_arb #(.NCH(NCH), .MSZ(MSZ), .PSZ(PSZ), .FSZ(FSZ),
               .RCV_REQ_CKS(RCK), .SND_ACK_CKS(ACK)) dut (
    .i_clk(i_clk), .reset(reset), .ready(ready), .rcv_req(rcv_req),
    .rcv_data(rcv_data), .rcv_ack(rcv_ack), .snd_req(snd_req), .snd_ack(snd_ack),
    .snd_pakio(snd_pakio), .snd_last(snd_last), .busy(busy));

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic last; logic [PSZ-1:0] data;} pkt_t;
  typedef struct packed {logic [7:0] src; logic [MSZ-1:0] msg;} ent_t;

  ent_t fifo[$];
  pkt_t pkts[$];
  bit   m_reqf[NCH];
  int   m_run_r[NCH];
  bit   m_ackf;
  int   m_run_a;
  bit   m_ack[NCH];
  int   m_rr;
  bit   m_sending;
  bit   m_ready;

  task automatic load_message(input ent_t e);
    logic [63:0] m64;
    pkts.delete();
    if (HDR != 0) pkts.push_back('{1'b0, PSZ'(int'(e.src) * (1 << PCW) + TOT_PKS)});
    m64 = 64'(e.msg);
    for (int j = 0; j < TOT_PKS; j++)
      pkts.push_back('{(j == TOT_PKS - 1), PSZ'(m64 >> (j * PSZ))});
  endtask

  task automatic model_step();
    bit old_reqf[NCH];
    bit old_ackf;
    bit full;
    int win;
    if (reset) begin
      fifo.delete(); pkts.delete();
      for (int i = 0; i < NCH; i++) begin m_reqf[i] = 0; m_run_r[i] = 0; m_ack[i] = 0; end
      m_ackf = 0; m_run_a = 0; m_rr = 0; m_sending = 0; m_ready = 0;
      return;
    end
    m_ready  = 1;
    old_reqf = m_reqf;
    old_ackf = m_ackf;
    full     = (fifo.size() == FSZ);
    win      = -1;
    for (int k = 0; k < NCH; k++) begin
      int c = (m_rr + k) % NCH;
      if (win < 0 && old_reqf[c] && !m_ack[c] && !full) win = c;
    end
    for (int i = 0; i < NCH; i++) if (!old_reqf[i]) m_ack[i] = 0;
    // output side: idle means no packets outstanding
    if (pkts.size() == 0) begin
      if (fifo.size() > 0) begin
        load_message(fifo.pop_front());
        m_sending = 1;
      end
    end else if (m_sending) begin
      if (old_ackf) m_sending = 0;
    end else if (!old_ackf) begin
      void'(pkts.pop_front());
      if (pkts.size() > 0) m_sending = 1;
    end
    if (win >= 0) begin
      fifo.push_back('{8'(win), rcv_data[win*MSZ +: MSZ]});
      m_ack[win] = 1;
      m_rr = (win + 1) % NCH;
    end
    // filtered levels move after RCK / ACK consecutive samples at the new level
    for (int i = 0; i < NCH; i++) begin
      if (rcv_req[i] == m_reqf[i]) m_run_r[i] = 0;
      else if (++m_run_r[i] >= RCK) begin m_reqf[i] = rcv_req[i]; m_run_r[i] = 0; end
    end
    if (snd_ack == m_ackf) m_run_a = 0;
    else if (++m_run_a >= ACK) begin m_ackf = snd_ack; m_run_a = 0; end
  endtask

  // ---------------- stimulus agents ----------------
  bit   hold_ack = 1;
  int   ack_dly  = 2;
  int   req_prob = 0;
  int   ack_glitch = 0;
  bit   hist[4];
  logic prev_req = 0;
  logic [PSZ:0] cap[$];

  task automatic check_outputs();
    check("ready", ready, m_ready);
    for (int i = 0; i < NCH; i++) check($sformatf("rcv_ack%0d", i), rcv_ack[i], m_ack[i]);
    check("snd_req", snd_req, m_sending);
    check("snd_pakio", snd_pakio, m_sending ? pkts[0].data : '0);
    check("snd_last", snd_last, m_sending ? pkts[0].last : 1'b0);
    check("busy", busy, (fifo.size() != 0) || (pkts.size() != 0));
    if (snd_req && !prev_req) cap.push_back({snd_last, snd_pakio});
    prev_req = snd_req;
  endtask

  task automatic drive();
    for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = m_sending;
    snd_ack = hold_ack ? 1'b0 : hist[ack_dly];
    if (ack_glitch > 0 && $urandom_range(99) < ack_glitch) snd_ack = ~snd_ack;
    for (int i = 0; i < NCH; i++) begin
      if (rcv_req[i] && m_ack[i]) rcv_req[i] = 1'b0;
      else if (!rcv_req[i] && !m_ack[i] && $urandom_range(99) < req_prob) begin
        rcv_data[i*MSZ +: MSZ] = $urandom;
        rcv_req[i] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge i_clk);
    model_step();
    check_outputs();
    drive();
  endtask

  function automatic bit model_quiet();
    bit q = (fifo.size() == 0) && (pkts.size() == 0) && (rcv_req == '0);
    for (int i = 0; i < NCH; i++) q = q && !m_ack[i] && !m_reqf[i];
    return q;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    req_prob = 0; hold_ack = 0; ack_glitch = 0;
    while (!model_quiet() && n < 800) begin cycle(); n++; end
    check({tag, "_drain_timeout"}, n < 800, 1'b1);
    repeat (3) cycle();
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic directed(input int ch, input logic [MSZ-1:0] d, input logic [7:0] e[5]);
    int lat = 0;
    bit seen = 0;
    cap.delete();
    req_prob = 0; hold_ack = 0; ack_dly = 2;
    rcv_data[ch*MSZ +: MSZ] = d;
    rcv_req[ch] = 1'b1;
    for (int n = 0; n < 80; n++) begin
      cycle();
      if (!seen) begin lat++; if (rcv_ack[ch]) seen = 1; end
    end
    check($sformatf("ack_latency_ch%0d", ch), lat, RCK + 1);
    check($sformatf("pkt_count_ch%0d", ch), cap.size(), TOT_PKS + HDR);
    for (int j = 0; j < TOT_PKS + HDR && j < cap.size(); j++) begin
      check($sformatf("pkt%0d_ch%0d", j, ch), cap[j][PSZ-1:0], e[j + 1 - HDR]);
      check($sformatf("last%0d_ch%0d", j, ch), cap[j][PSZ], j == TOT_PKS + HDR - 1);
    end
  endtask

  initial begin
    logic [7:0] e0[5];
    logic [7:0] e1[5];
    int src_hist[$];
    logic [NCH-1:0] prev_ack;
    int n;

    e0 = '{8'h04, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    e1 = '{8'h0C, 8'h44, 8'h33, 8'h22, 8'h11};

    // T1: reset for 3 cycles, then ready on the first cycle after release
    repeat (3) begin
      cycle();
      check("rst_ready", ready, 1'b0);
      check("rst_snd_req", snd_req, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    reset = 1'b0;
    cycle();
    check("ready_after_reset", ready, 1'b1);

    // T2/T3: single messages, packets low byte first, optional header
    directed(0, 32'hA1B2C3D4, e0);
    directed(1, 32'h11223344, e1);
    drain("t2");

    // T4: both channels request continuously; pushes alternate
    req_prob = 100; ack_dly = 0; hold_ack = 0;
    prev_ack = '0;
    for (int c = 0; c < 120; c++) begin
      cycle();
      for (int i = 0; i < NCH; i++) if (rcv_ack[i] && !prev_ack[i]) src_hist.push_back(i);
      prev_ack = rcv_ack;
    end
    check("t4_push_count", src_hist.size() >= 6, 1'b1);
    for (int k = 1; k < src_hist.size() && k < 8; k++)
      check($sformatf("t4_alternate%0d", k), src_hist[k], 1 - src_hist[k-1]);
    drain("t4");

    // T5: output stalled, FIFO fills, further pushes refused, then drains in order
    hold_ack = 1; req_prob = 100;
    repeat (60) cycle();
    check("t5_acks_blocked", rcv_ack, '0);
    check("t5_busy_full", busy, 1'b1);
    check("t5_snd_req_held", snd_req, 1'b1);
    drain("t5");

    // T6a: one-cycle snd_ack glitch is ignored
    hold_ack = 1; req_prob = 0;
    rcv_data[0 +: MSZ] = 32'hCAFE0001;
    rcv_req[0] = 1'b1;
    n = 0;
    while (!m_sending && n < 40) begin cycle(); n++; end
    check("t6_send_timeout", n < 40, 1'b1);
    snd_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t6_glitch_snd_req", snd_req, 1'b1);
    end

    // T6b: reset mid-packet aborts the message
    reset = 1'b1;
    cycle();
    check("t6_abort_snd_req", snd_req, 1'b0);
    check("t6_abort_busy", busy, 1'b0);
    check("t6_abort_ready", ready, 1'b0);
    reset = 1'b0;
    cycle();
    check("t6_ready_again", ready, 1'b1);
    check("t6_fifo_empty", busy, 1'b0);
    drain("t6");

    // Randomized traffic with varying echo delay, stalls and ack glitches
    for (int seg = 0; seg < 10; seg++) begin
      ack_dly    = $urandom_range(3);
      req_prob   = $urandom_range(100, 10);
      hold_ack   = ($urandom_range(5) == 0);
      ack_glitch = $urandom_range(3);
      repeat (200) cycle();
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
